// File: rtl/carry_out_gen_if.sv
// Carry-out stage bundle: per-slice carries and mode qualifiers in, qualified carries out.
// Latency: none (signal container only).
// Backpressure: none; CEP is the only flow qualifier and it stalls the output register.
//
// Ports (via modports):
//   cep          - clock enable of the carry-out register (shared with P register)
//   carry_int    - raw adder carries out of bits 11/23/35/47
//   alumode      - current ALU operation code
//   mult_active  - multiplier routed into X/Y this cycle
//   mult_sign    - sign bit of the multiplier product
//   carryout     - qualified per-segment carry out to fabric
//   carrycascout - cascaded carry to the next slice
//   multsignout  - cascaded multiplier sign to the next slice
interface carry_out_gen_if;
    logic       cep;
    logic [3:0] carry_int;
    logic [3:0] alumode;
    logic       mult_active;
    logic       mult_sign;
    logic [3:0] carryout;
    logic       carrycascout;
    logic       multsignout;

    modport master (
        output cep, carry_int, alumode, mult_active, mult_sign,
        input  carryout, carrycascout, multsignout
    );

    modport slave (
        input  cep, carry_int, alumode, mult_active, mult_sign,
        output carryout, carrycascout, multsignout
    );
endinterface

// File: rtl/carry_out_gen.sv
// Qualifies raw segment carries by SIMD mode, ALU op and multiplier use for fabric and cascade.
// Latency: 1 enabled CLK edge when CARRYOUTREG=1, combinational when CARRYOUTREG=0.
// Backpressure: CEP=0 freezes the output register (RSTP ignored while frozen).
//
// Ports:
//   CLK  - slice clock
//   RSTP - synchronous active-high reset, only effective together with CEP
//   io   - carry_out_gen_if.slave bundle (enable, carries, mode inputs, qualified outputs)
module carry_out_gen #(
    parameter int CARRYOUTREG = 1,
    parameter int USE_SIMD    = 0
) (
    input  logic              CLK,
    input  logic              RSTP,
    carry_out_gen_if.slave    io
);

    // Segment keep-mask: carries only leave at the top of each active segment.
    // Unknown USE_SIMD values fall back to a single 48-bit segment.
    localparam logic [3:0] SEG_MASK = (USE_SIMD == 2) ? 4'b1111 :
                                      (USE_SIMD == 1) ? 4'b1010 :
                                                        4'b1000;

    logic       is_sub;
    logic       is_logic;
    logic [3:0] carry_adj;
    logic [3:0] carryout_d;
    logic       carrycascout_d;
    logic       multsignout_d;

    logic [3:0] carryout_q;
    logic       carrycascout_q;
    logic       multsignout_q;

    always_comb begin
        is_sub   = (io.alumode == 4'b0011);
        is_logic = (io.alumode[3:2] != 2'b00);

        // Z-(X+Y+CIN) reports a borrow, which is the complement of the adder carry.
        carry_adj = io.carry_int ^ {4{is_sub}};

        carryout_d     = '0;
        carrycascout_d = 1'b0;
        multsignout_d  = io.mult_active & io.mult_sign;

        if (!is_logic) begin
            // The cascade always follows bit 47, independent of segmentation, and
            // is still produced while the multiplier is in use.
            carrycascout_d = carry_adj[3];
            if (!io.mult_active) begin
                carryout_d = carry_adj & SEG_MASK;
            end
        end
    end

    // Built unconditionally; the output select below drops it when CARRYOUTREG=0.
    always_ff @(posedge CLK) begin
        if (io.cep) begin
            if (RSTP) begin
                carryout_q     <= '0;
                carrycascout_q <= 1'b0;
                multsignout_q  <= 1'b0;
            end else begin
                carryout_q     <= carryout_d;
                carrycascout_q <= carrycascout_d;
                multsignout_q  <= multsignout_d;
            end
        end
    end

    assign io.carryout     = (CARRYOUTREG != 0) ? carryout_q     : carryout_d;
    assign io.carrycascout = (CARRYOUTREG != 0) ? carrycascout_q : carrycascout_d;
    assign io.multsignout  = (CARRYOUTREG != 0) ? multsignout_q  : multsignout_d;

endmodule

// File: tb/tb_carry_out_gen.sv
// Directed bench for carry_out_gen: three registered instances (ONE48/TWO24/FOUR12) and
// one combinational FOUR12 instance share the same stimulus.
// Vector table covers qualification; hand sequences cover reset, CEP hold and pass-through.
module tb_carry_out_gen;

    logic       clk;
    logic       rstp;
    logic       cep;
    logic [3:0] carry_int;
    logic [3:0] alumode;
    logic       mult_active;
    logic       mult_sign;

    int checks;
    int errors;

    // Instance 0: REG ONE48, 1: REG TWO24, 2: REG FOUR12, 3: COMB FOUR12
    carry_out_gen_if ifs [4] ();

    for (genvar g = 0; g < 4; g++) begin : gen_dut
        assign ifs[g].cep         = cep;
        assign ifs[g].carry_int   = carry_int;
        assign ifs[g].alumode     = alumode;
        assign ifs[g].mult_active = mult_active;
        assign ifs[g].mult_sign   = mult_sign;

        carry_out_gen #(
            .CARRYOUTREG ((g == 3) ? 0 : 1),
            .USE_SIMD    ((g == 3) ? 2 : g)
        ) u_dut (
            .CLK  (clk),
            .RSTP (rstp),
            .io   (ifs[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] carry;
        logic [3:0] alu;
        logic       ma;
        logic       ms;
        logic [3:0] exp48;
        logic [3:0] exp24;
        logic [3:0] exp12;
        logic       exp_casc;
        logic       exp_msign;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input string tag, input logic [3:0] e48, input logic [3:0] e24,
                           input logic [3:0] e12, input logic ec, input logic em);
        chk({tag, " co48"},   ifs[0].carryout,            e48);
        chk({tag, " co24"},   ifs[1].carryout,            e24);
        chk({tag, " co12"},   ifs[2].carryout,            e12);
        chk({tag, " casc48"}, {3'b000, ifs[0].carrycascout}, {3'b000, ec});
        chk({tag, " casc12"}, {3'b000, ifs[2].carrycascout}, {3'b000, ec});
        chk({tag, " msign"},  {3'b000, ifs[0].multsignout},  {3'b000, em});
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //            carry    alu      ma    ms    exp48    exp24    exp12    casc  msign
        vecs[0] = '{4'b1111, 4'b0000, 1'b0, 1'b0, 4'b1000, 4'b1010, 4'b1111, 1'b1, 1'b0};
        vecs[1] = '{4'b0101, 4'b0011, 1'b0, 1'b0, 4'b1000, 4'b1010, 4'b1010, 1'b1, 1'b0};
        vecs[2] = '{4'b1000, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1};
        vecs[3] = '{4'b1000, 4'b0100, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1};
        vecs[4] = '{4'b0110, 4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0010, 4'b0110, 1'b0, 1'b0};
        vecs[5] = '{4'b0000, 4'b0011, 1'b0, 1'b0, 4'b1000, 4'b1010, 4'b1111, 1'b1, 1'b0};
        vecs[6] = '{4'b1111, 4'b1100, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[7] = '{4'b0111, 4'b0010, 1'b0, 1'b1, 4'b0000, 4'b0010, 4'b0111, 1'b0, 1'b0};

        // Reset with inputs that would otherwise produce nonzero outputs.
        rstp        = 1'b1;
        cep         = 1'b1;
        carry_int   = 4'b1111;
        alumode     = 4'b0000;
        mult_active = 1'b1;
        mult_sign   = 1'b1;
        tick();
        tick();
        chk_reg("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);

        // Table: mode and data change together each cycle, outputs follow one edge later.
        rstp = 1'b0;
        for (int i = 0; i < 8; i++) begin
            carry_int   = vecs[i].carry;
            alumode     = vecs[i].alu;
            mult_active = vecs[i].ma;
            mult_sign   = vecs[i].ms;
            #1;
            chk($sformatf("vec%0d comb co12", i), ifs[3].carryout, vecs[i].exp12);
            chk($sformatf("vec%0d comb casc", i), {3'b000, ifs[3].carrycascout},
                {3'b000, vecs[i].exp_casc});
            tick();
            chk_reg($sformatf("vec%0d", i), vecs[i].exp48, vecs[i].exp24, vecs[i].exp12,
                    vecs[i].exp_casc, vecs[i].exp_msign);
        end

        // Load a known value, then freeze with CEP=0 while inputs change and RSTP pulses.
        carry_int   = 4'b1111;
        alumode     = 4'b0000;
        mult_active = 1'b0;
        mult_sign   = 1'b0;
        tick();
        chk_reg("preload", 4'b1000, 4'b1010, 4'b1111, 1'b1, 1'b0);

        cep         = 1'b0;
        rstp        = 1'b1;
        carry_int   = 4'b0111;
        mult_active = 1'b1;
        mult_sign   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_reg($sformatf("hold%0d", c), 4'b1000, 4'b1010, 4'b1111, 1'b1, 1'b0);
        end

        // Enable with reset asserted: reset wins.
        cep = 1'b1;
        tick();
        chk_reg("rst_en", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);

        // Release reset: live inputs reload on the very next edge.
        rstp = 1'b0;
        tick();
        chk_reg("reload", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);

        // Combinational instance follows inputs immediately, whatever CEP/RSTP do.
        alumode     = 4'b0000;
        mult_active = 1'b0;
        mult_sign   = 1'b0;
        cep         = 1'b0;
        rstp        = 1'b1;
        carry_int   = 4'b0000;
        #1;
        chk("comb 0000", ifs[3].carryout, 4'b0000);
        carry_int = 4'b1111;
        #1;
        chk("comb 1111", ifs[3].carryout, 4'b1111);
        chk("comb casc", {3'b000, ifs[3].carrycascout}, 4'b0001);
        cep       = 1'b1;
        carry_int = 4'b0110;
        #1;
        chk("comb 0110", ifs[3].carryout, 4'b0110);
        tick();
        chk("comb after edge", ifs[3].carryout, 4'b0110);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
